// File: rtl/missile_sched_pkg.sv
// Shared types and default constants for the missile launch scheduler.
`timescale 1ns/1ps
package missile_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        LAUNCH = 2'd2
    } state_t;

    localparam int DEF_N_REQ        = 4;
    localparam int DEF_N_SLOTS      = 4;
    localparam int DEF_CD_W         = 6;
    localparam int DEF_REQ_COOLDOWN = 60;
    localparam int DEF_FIRE_GAP     = 15;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Reservation watchdog: a slot whose explored flag never drops is
    // released 255 Clk after its launch.
    localparam int             WD_W     = 8;
    localparam logic [WD_W-1:0] WD_LIMIT = 8'd254;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first eligible bit at or above ptr,
// wrapping from N-1 back to 0.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    // Scan N positions starting at ptr and keep the first hit
    always_comb begin
        int unsigned idx;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && eligible[idx]) begin
                any          = 1'b1;
                win_idx      = IW'(idx);
                win[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/missile_launch_scheduler.sv
// Shares a pool of missile slots between several shooters: one round-robin
// grant per frame, lowest free slot, one-Clk launch pulse with held start
// coordinates.
`timescale 1ns/1ps
module missile_launch_scheduler
    import missile_sched_pkg::*;
#(
    parameter int N_REQ        = DEF_N_REQ,
    parameter int N_SLOTS      = DEF_N_SLOTS,
    parameter int CD_W         = DEF_CD_W,
    parameter int REQ_COOLDOWN = DEF_REQ_COOLDOWN,
    parameter int FIRE_GAP     = DEF_FIRE_GAP
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_clk,
    input  logic   [N_REQ-1:0]        req,
    input  coord_t [N_REQ-1:0]        req_x,
    input  coord_t [N_REQ-1:0]        req_y,
    input  logic   [N_SLOTS-1:0]      slot_explored,
    output logic   [N_SLOTS-1:0]      launch,
    output coord_t [N_SLOTS-1:0]      slot_start_x,
    output coord_t [N_SLOTS-1:0]      slot_start_y,
    output logic   [N_REQ-1:0]        grant,
    output logic   [N_SLOTS-1:0]      busy_slots
);

    localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [CD_W-1:0] REQ_RELOAD = CD_W'(REQ_COOLDOWN);
    localparam logic [CD_W-1:0] GAP_RELOAD = CD_W'(FIRE_GAP);

    function automatic logic [CD_W-1:0] dec_sat(input logic [CD_W-1:0] v);
        return (v == '0) ? v : v - CD_W'(1);
    endfunction

    state_t                         state, state_next;
    logic                           frame_d, fedge, pending;
    logic [RW-1:0]                  rr_ptr;
    logic [N_REQ-1:0][CD_W-1:0]     req_cd;
    logic [CD_W-1:0]                gap_cd;
    logic [N_SLOTS-1:0]             reserved;
    logic [N_SLOTS-1:0][WD_W-1:0]   wd_cnt;

    logic [N_REQ-1:0]               eligible;
    logic [N_REQ-1:0]               arb_win;
    logic [RW-1:0]                  arb_idx;
    logic                           arb_any;
    logic [N_SLOTS-1:0]             free;
    logic [SW-1:0]                  slot_idx;
    logic                           slot_any;
    logic                           do_launch;

    logic [N_REQ-1:0]               win_oh_q;
    logic [RW-1:0]                  win_q;
    logic [SW-1:0]                  slot_q;

    // Registered rising-edge detect of the frame strobe
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_d <= 1'b0;
            fedge   <= 1'b0;
        end else begin
            frame_d <= frame_clk;
            fedge   <= frame_clk & ~frame_d;
        end
    end

    // Remember a frame edge that arrives while ARB/LAUNCH is in progress
    always_ff @(posedge Clk) begin
        if (Reset)
            pending <= 1'b0;
        else if (state == IDLE)
            pending <= 1'b0;
        else if (fedge)
            pending <= 1'b1;
    end

    // Shooter eligibility: requesting and out of cooldown
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++)
            eligible[i] = req[i] & (req_cd[i] == '0);
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .win      (arb_win),
        .win_idx  (arb_idx),
        .any      (arb_any)
    );

    // Lowest-index idle, unreserved slot
    always_comb begin
        free     = slot_explored & ~reserved;
        slot_any = 1'b0;
        slot_idx = '0;
        for (int s = N_SLOTS - 1; s >= 0; s--) begin
            if (free[s]) begin
                slot_any = 1'b1;
                slot_idx = SW'(s);
            end
        end
    end

    assign do_launch = (state == ARB) && arb_any && slot_any;

    // Latch winner, slot and start coordinates in the deciding ARB cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            win_oh_q     <= '0;
            win_q        <= '0;
            slot_q       <= '0;
            slot_start_x <= '0;
            slot_start_y <= '0;
        end else if (do_launch) begin
            win_oh_q               <= arb_win;
            win_q                  <= arb_idx;
            slot_q                 <= slot_idx;
            slot_start_x[slot_idx] <= req_x[arb_idx];
            slot_start_y[slot_idx] <= req_y[arb_idx];
        end
    end

    // Round-robin pointer moves past the shooter that actually fired
    always_ff @(posedge Clk) begin
        if (Reset)
            rr_ptr <= '0;
        else if (state == LAUNCH)
            rr_ptr <= (int'(win_q) == N_REQ - 1) ? '0 : win_q + RW'(1);
    end

    // Cooldowns: reload on launch wins over the per-frame decrement
    always_ff @(posedge Clk) begin
        if (Reset) begin
            req_cd <= '0;
            gap_cd <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (state == LAUNCH && win_q == RW'(i))
                    req_cd[i] <= REQ_RELOAD;
                else if (fedge)
                    req_cd[i] <= dec_sat(req_cd[i]);
            end
            if (state == LAUNCH)
                gap_cd <= GAP_RELOAD;
            else if (fedge)
                gap_cd <= dec_sat(gap_cd);
        end
    end

    // Slot reservation covers the gap until the missile drops explored
    always_ff @(posedge Clk) begin
        if (Reset) begin
            reserved <= '0;
            wd_cnt   <= '0;
        end else begin
            for (int s = 0; s < N_SLOTS; s++) begin
                if (state == LAUNCH && slot_q == SW'(s)) begin
                    reserved[s] <= 1'b1;
                    wd_cnt[s]   <= '0;
                end else if (reserved[s]) begin
                    if (!slot_explored[s] || wd_cnt[s] == WD_LIMIT)
                        reserved[s] <= 1'b0;
                    wd_cnt[s] <= wd_cnt[s] + WD_W'(1);
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if ((fedge || pending) && gap_cd == '0) state_next = ARB;
            ARB:     state_next = (arb_any && slot_any) ? LAUNCH : IDLE;
            LAUNCH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: one-Clk launch and grant pulses
    always_comb begin
        launch = '0;
        grant  = '0;
        if (state == LAUNCH) begin
            launch[slot_q] = 1'b1;
            grant          = win_oh_q;
        end
    end

    assign busy_slots = ~slot_explored | reserved;

endmodule

// File: tb/tb_missile_launch_scheduler.sv
// Directed testbench for missile_launch_scheduler: a default-parameter
// instance and a zero-cooldown instance share the same stimulus.
`timescale 1ns/1ps
module tb_missile_launch_scheduler;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             frame_clk;
    logic [3:0]       req;
    logic [3:0][9:0]  req_x, req_y;
    logic [3:0]       slot_explored;

    logic [3:0]       launch_def, grant_def, busy_def;
    logic [3:0][9:0]  sx_def, sy_def;
    logic [3:0]       launch_fst, grant_fst, busy_fst;
    logic [3:0][9:0]  sx_fst, sy_fst;

    int n_checks = 0;
    int n_fail   = 0;

    // Captured per frame: outputs in the LAUNCH cycle and any pulse elsewhere
    logic [3:0] fl_def, fg_def, fl_fst, fg_fst, stray_def, stray_fst;

    always #10 Clk = ~Clk;

    missile_launch_scheduler dut_def (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .req(req),
        .req_x(req_x), .req_y(req_y), .slot_explored(slot_explored),
        .launch(launch_def), .slot_start_x(sx_def), .slot_start_y(sy_def),
        .grant(grant_def), .busy_slots(busy_def)
    );

    missile_launch_scheduler #(.REQ_COOLDOWN(0), .FIRE_GAP(0)) dut_fst (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .req(req),
        .req_x(req_x), .req_y(req_y), .slot_explored(slot_explored),
        .launch(launch_fst), .slot_start_x(sx_fst), .slot_start_y(sy_fst),
        .grant(grant_fst), .busy_slots(busy_fst)
    );

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // One frame strobe; cycle 0 after the edge is the fedge cycle, cycle 2 is LAUNCH
    task automatic do_frame();
        @(negedge Clk);
        frame_clk = 1'b1;
        fl_def = '0; fg_def = '0; fl_fst = '0; fg_fst = '0;
        stray_def = '0; stray_fst = '0;
        for (int c = 0; c < 8; c++) begin
            @(posedge Clk);
            #1;
            if (c == 2) begin
                fl_def = launch_def; fg_def = grant_def;
                fl_fst = launch_fst; fg_fst = grant_fst;
            end else begin
                stray_def = stray_def | launch_def | grant_def;
                stray_fst = stray_fst | launch_fst | grant_fst;
            end
            if (c == 3) frame_clk = 1'b0;
        end
    endtask

    task automatic test_reset();
        req = '0; req_x = '0; req_y = '0; slot_explored = 4'b1111;
        do_reset();
        #1;
        n_checks++;
        if (launch_def !== 4'b0000 || grant_def !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_def_pulses: got launch=%b grant=%b required 0000/0000", launch_def, grant_def);
        end
        n_checks++;
        if (busy_def !== 4'b0000 || sx_def !== '0 || sy_def !== '0) begin
            n_fail++;
            $display("FAIL reset_def_state: got busy=%b sx=%h sy=%h required busy=0000 coords=0", busy_def, sx_def, sy_def);
        end
        n_checks++;
        if (launch_fst !== 4'b0000 || grant_fst !== 4'b0000 || busy_fst !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_fst: got launch=%b grant=%b busy=%b required all 0000", launch_fst, grant_fst, busy_fst);
        end
    endtask

    task automatic test_single_launch();
        req = '0; req_x = '0; req_y = '0; slot_explored = 4'b1111;
        do_reset();
        req = 4'b0001; req_x[0] = 10'd100; req_y[0] = 10'd50;
        do_frame();
        n_checks++;
        if (fl_def !== 4'b0001 || fg_def !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_launch: got launch=%b grant=%b required 0001/0001", fl_def, fg_def);
        end
        n_checks++;
        if (stray_def !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_latency: got off-cycle pulses %b required 0000", stray_def);
        end
        n_checks++;
        if (sx_def[0] !== 10'd100 || sy_def[0] !== 10'd50) begin
            n_fail++;
            $display("FAIL single_coords: got x=%0d y=%0d required 100/50", sx_def[0], sy_def[0]);
        end
        n_checks++;
        if (busy_def !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_busy: got %b required 0001", busy_def);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g_exp [8];
        logic [9:0] x_exp [4];
        int k;
        g_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        x_exp = '{10'd200, 10'd201, 10'd202, 10'd203};
        req = '0; slot_explored = 4'b1111;
        do_reset();
        req = 4'b1111;
        req_x = {10'd203, 10'd202, 10'd201, 10'd200};
        req_y = {10'd303, 10'd302, 10'd301, 10'd300};
        for (int f = 0; f < 8; f++) begin
            k = f % 4;
            do_frame();
            n_checks++;
            if (fg_fst !== g_exp[f] || fl_fst !== g_exp[f]) begin
                n_fail++;
                $display("FAIL rr_frame%0d: got grant=%b launch=%b required %b/%b", f, fg_fst, fl_fst, g_exp[f], g_exp[f]);
            end
            n_checks++;
            if (sx_fst[k] !== x_exp[k]) begin
                n_fail++;
                $display("FAIL rr_coord%0d: got x=%0d required %0d", f, sx_fst[k], x_exp[k]);
            end
            @(negedge Clk);
            slot_explored[k] = 1'b0;
            if (k == 3) begin
                repeat (2) @(negedge Clk);
                slot_explored = 4'b1111;
            end
        end
    endtask

    task automatic test_cooldown();
        req = '0; slot_explored = 4'b1111;
        do_reset();
        req = 4'b0001; req_x[0] = 10'd7; req_y[0] = 10'd9;
        do_frame();
        n_checks++;
        if (fg_def !== 4'b0001) begin
            n_fail++;
            $display("FAIL cd_first: got grant=%b required 0001", fg_def);
        end
        for (int f = 2; f <= 60; f++) begin
            do_frame();
            n_checks++;
            if (fg_def !== 4'b0000 || fl_def !== 4'b0000) begin
                n_fail++;
                $display("FAIL cd_frame%0d: got grant=%b launch=%b required 0000/0000", f, fg_def, fl_def);
            end
        end
        do_frame();
        n_checks++;
        if (fg_def !== 4'b0001 || fl_def !== 4'b0001) begin
            n_fail++;
            $display("FAIL cd_frame61: got grant=%b launch=%b required 0001/0001", fg_def, fl_def);
        end
    endtask

    task automatic test_all_busy();
        req = '0; slot_explored = 4'b0000;
        do_reset();
        req = 4'b0010; req_x[1] = 10'd444; req_y[1] = 10'd333;
        for (int f = 0; f < 10; f++) begin
            do_frame();
            n_checks++;
            if (fl_def !== 4'b0000 || fl_fst !== 4'b0000) begin
                n_fail++;
                $display("FAIL busy_frame%0d: got launch def=%b fst=%b required 0000", f, fl_def, fl_fst);
            end
        end
        @(negedge Clk);
        slot_explored = 4'b0100;
        do_frame();
        n_checks++;
        if (fl_def !== 4'b0100 || fg_def !== 4'b0010) begin
            n_fail++;
            $display("FAIL busy_release_def: got launch=%b grant=%b required 0100/0010", fl_def, fg_def);
        end
        n_checks++;
        if (fl_fst !== 4'b0100 || sx_fst[2] !== 10'd444) begin
            n_fail++;
            $display("FAIL busy_release_fst: got launch=%b x=%0d required 0100/444", fl_fst, sx_fst[2]);
        end
    endtask

    task automatic test_watchdog();
        req = '0; slot_explored = 4'b1111;
        do_reset();
        req = 4'b0001;
        do_frame();
        n_checks++;
        if (fl_fst !== 4'b0001) begin
            n_fail++;
            $display("FAIL wd_first: got launch=%b required 0001", fl_fst);
        end
        do_frame();
        n_checks++;
        if (fl_fst !== 4'b0010) begin
            n_fail++;
            $display("FAIL wd_no_realloc: got launch=%b required 0010", fl_fst);
        end
        @(negedge Clk);
        slot_explored = 4'b0001;
        repeat (2) @(negedge Clk);
        do_frame();
        n_checks++;
        if (fl_fst !== 4'b0000 || busy_fst !== 4'b1111) begin
            n_fail++;
            $display("FAIL wd_held: got launch=%b busy=%b required 0000/1111", fl_fst, busy_fst);
        end
        repeat (250) @(negedge Clk);
        do_frame();
        n_checks++;
        if (fl_fst !== 4'b0001) begin
            n_fail++;
            $display("FAIL wd_release: got launch=%b required 0001", fl_fst);
        end
    endtask

    task automatic test_reset_mid_launch();
        req = '0; slot_explored = 4'b1111;
        do_reset();
        req = 4'b0111;
        do_frame();
        n_checks++;
        if (fg_fst !== 4'b0001 || fg_def !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got grant fst=%b def=%b required 0001/0001", fg_fst, fg_def);
        end
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if (grant_fst !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_mid_inlaunch: got grant=%b required 0010", grant_fst);
        end
        Reset = 1'b1;
        frame_clk = 1'b0;
        @(posedge Clk);
        #1;
        n_checks++;
        if (launch_fst !== 4'b0000 || grant_fst !== 4'b0000 || launch_def !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_pulse: got launch fst=%b grant fst=%b launch def=%b required 0000", launch_fst, grant_fst, launch_def);
        end
        n_checks++;
        if (busy_fst !== 4'b0000 || busy_def !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_reserved: got busy fst=%b def=%b required 0000/0000", busy_fst, busy_def);
        end
        @(negedge Clk);
        Reset = 1'b0;
        do_frame();
        n_checks++;
        if (fg_fst !== 4'b0001 || fl_fst !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_rrptr: got grant=%b launch=%b required 0001/0001", fg_fst, fl_fst);
        end
        n_checks++;
        if (fg_def !== 4'b0001 || fl_def !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_cooldown: got grant=%b launch=%b required 0001/0001", fg_def, fl_def);
        end
    endtask

    initial begin
        Reset = 1'b1;
        frame_clk = 1'b0;
        req = '0; req_x = '0; req_y = '0; slot_explored = 4'b1111;
        test_reset();
        test_single_launch();
        test_round_robin();
        test_cooldown();
        test_all_busy();
        test_watchdog();
        test_reset_mid_launch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
